// File: rtl/bitwise_logic_unit.sv
// Single-stage bitwise logic unit: selectable 2-operand logic function with an
// optional internal accumulator, valid/ready handshake on both sides and a beat counter.
module bitwise_logic_unit #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic [15:0]      beat_cnt
);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] bb
  );
    logic [WIDTH-1:0] res;
    case (sel)
      3'd0:    res = x & bb;
      3'd1:    res = x | bb;
      3'd2:    res = ~x;
      3'd3:    res = ~bb;
      3'd4:    res = ~(x & bb);
      3'd5:    res = ~(x | bb);
      3'd6:    res = x ^ bb;
      default: res = ~(x ^ bb);
    endcase
    return res;
  endfunction

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_y_zero;
  logic             r_y_parity;
  logic [15:0]      r_beat_cnt;
  logic [WIDTH-1:0] r_acc;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_result;

  // The output register frees up in the same cycle it is drained, so no bubble.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // A clear in the same beat makes the accumulator operand start from ACC_INIT.
  assign w_x      = acc_mode ? (acc_clr ? ACC_INIT : r_acc) : a;
  assign w_result = f_logic_op(op, w_x, b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_zero    <= 1'b1;
      r_y_parity  <= 1'b0;
      r_beat_cnt  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_y_zero    <= (w_result == '0);
      r_y_parity  <= ^w_result;
      r_beat_cnt  <= r_beat_cnt + 16'd1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && acc_mode) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_zero    = r_y_zero;
  assign y_parity  = r_y_parity;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit (WIDTH=8, ACC_INIT=0).
module tb_bitwise_logic_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        acc_mode;
  logic        acc_clr;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        y_zero;
  logic        y_parity;
  logic [15:0] beat_cnt;

  bitwise_logic_unit #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_zero(y_zero),
    .y_parity(y_parity), .beat_cnt(beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_acc;
  logic        m_vld;
  logic [15:0] m_cnt;
  logic        obs_ready;
  logic        exp_ready;
  logic [7:0]  last_y;

  function automatic logic [7:0] model_r(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] bb);
    logic [7:0] r;
    case (o)
      3'd0: r = x & bb;
      3'd1: r = x | bb;
      3'd2: r = ~x;
      3'd3: r = ~bb;
      3'd4: r = ~(x & bb);
      3'd5: r = ~(x | bb);
      3'd6: r = x ^ bb;
      default: r = ~(x ^ bb);
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs, update the model, push expected output, advance past the edge.
  task automatic step(input logic iv, input logic [2:0] o, input logic am, input logic ac,
                      input logic [7:0] ia, input logic [7:0] ib, input logic ordy);
    logic [7:0] x;
    logic [7:0] r;
    logic       acc_ok;
    in_valid = iv; op = o; acc_mode = am; acc_clr = ac; a = ia; b = ib; out_ready = ordy;
    exp_ready = !m_vld || ordy;
    acc_ok = iv && exp_ready;
    x = am ? (ac ? 8'h00 : m_acc) : ia;
    r = model_r(o, x, ib);
    if (acc_ok) begin
      sb.push_back({r, (r == 8'h00), ^r});
      m_vld = 1'b1;
      m_cnt = m_cnt + 16'd1;
      if (am) m_acc = r;
      else if (ac) m_acc = 8'h00;
    end else begin
      if (ordy) m_vld = 1'b0;
      if (ac) m_acc = 8'h00;
    end
    #1;
    obs_ready = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 8'h00;
    m_vld = 1'b0;
    m_cnt = 16'h0000;
    sb.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; op = 3'd3; acc_mode = 1'b0; acc_clr = 1'b0; a = 8'h00; b = 8'h00;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, y, y_zero, y_parity, beat_cnt, in_ready} !== {1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b y=%h z=%b p=%b cnt=%h rdy=%b, want ov=0 y=00 z=1 p=0 cnt=0000 rdy=1",
               out_valid, y, y_zero, y_parity, beat_cnt, in_ready);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, beat_cnt} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_release_idle: got ov=%b cnt=%h, want ov=0 cnt=0000", out_valid, beat_cnt);
    end
  endtask

  task automatic test_xor();
    step(1'b1, 3'd6, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({out_valid, y, y_zero, y_parity, beat_cnt} !== {1'b1, 8'hCC, 1'b0, 1'b0, 16'h0001}) begin
      errors++;
      $display("FAIL xor_beat: got ov=%b y=%h z=%b p=%b cnt=%h, want ov=1 y=cc z=0 p=0 cnt=0001",
               out_valid, y, y_zero, y_parity, beat_cnt);
    end
    checks++;
    if ({y, y_zero, y_parity} !== {e.y, e.z, e.p}) begin
      errors++;
      $display("FAIL xor_scoreboard: got y=%h z=%b p=%b, want y=%h z=%b p=%b",
               y, y_zero, y_parity, e.y, e.z, e.p);
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] tbl [8];
    tbl = '{8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'hAA, 8'h55};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 1'b0, 1'b0, 8'hA5, 8'h0F, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({out_valid, y, y_zero, y_parity, beat_cnt} !== {1'b1, tbl[i], e.z, e.p, m_cnt}) begin
        errors++;
        $display("FAIL op_sweep_%0d: got ov=%b y=%h z=%b p=%b cnt=%h, want ov=1 y=%h z=%b p=%b cnt=%h",
                 i, out_valid, y, y_zero, y_parity, beat_cnt, tbl[i], e.z, e.p, m_cnt);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h33, 1'b1);
    e = sb.pop_front();
    last_y = e.y;
    checks++;
    if ({out_valid, y} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL stall_first: got ov=%b y=%h, want ov=1 y=33", out_valid, y);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 1'b0, 1'b0, 8'h40, 8'h04, 1'b0);
      checks++;
      if ({obs_ready, out_valid, y, beat_cnt} !== {1'b0, 1'b1, last_y, m_cnt} || sb.size() != 0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rdy=%b ov=%b y=%h cnt=%h, want rdy=0 ov=1 y=%h cnt=%h",
                 i, obs_ready, out_valid, y, beat_cnt, last_y, m_cnt);
      end
    end
    step(1'b1, 3'd1, 1'b0, 1'b0, 8'h40, 8'h04, 1'b1);
    checks++;
    if (sb.size() != 1 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_accept: got rdy=%b queued=%0d, want rdy=1 queued=1", obs_ready, sb.size());
      sb.delete();
    end else begin
      e = sb.pop_front();
      if ({out_valid, y, beat_cnt} !== {1'b1, 8'h44, m_cnt}) begin
        errors++;
        $display("FAIL stall_release_data: got ov=%b y=%h cnt=%h, want ov=1 y=44 cnt=%h",
                 out_valid, y, beat_cnt, m_cnt);
      end
    end
    step(1'b1, 3'd7, 1'b0, 1'b0, 8'h0F, 8'h0F, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({out_valid, y, y_zero, y_parity} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL no_bubble: got ov=%b y=%h z=%b p=%b, want ov=1 y=ff z=0 p=0",
               out_valid, y, y_zero, y_parity);
    end
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({out_valid, y} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL drain_hold_y: got ov=%b y=%h, want ov=0 y=ff", out_valid, y);
    end
  endtask

  task automatic test_acc();
    logic [7:0] bs  [4];
    logic [7:0] exp [4];
    bs  = '{8'h01, 8'h02, 8'h04, 8'h10};
    exp = '{8'h01, 8'h03, 8'h07, 8'h10};
    step(1'b1, 3'd0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, 1'b1, (i == 3), 8'hEE, bs[i], 1'b1);
      e = sb.pop_front();
      checks++;
      if ({out_valid, y, y_zero, y_parity} !== {1'b1, exp[i], e.z, e.p} || e.y !== exp[i]) begin
        errors++;
        $display("FAIL acc_chain_%0d: got ov=%b y=%h, want ov=1 y=%h (model %h)",
                 i, out_valid, y, exp[i], e.y);
      end
    end
    step(1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({out_valid, y} !== {1'b0, 8'h10}) begin
      errors++;
      $display("FAIL acc_clr_idle: got ov=%b y=%h, want ov=0 y=10", out_valid, y);
    end
    step(1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1);
    e = sb.pop_front();
    checks++;
    if (y !== 8'h01 || e.y !== 8'h01) begin
      errors++;
      $display("FAIL acc_after_idle_clr: got y=%h, want y=01", y);
    end
    step(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    e = sb.pop_front();
    step(1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({y, y_parity} !== {8'h03, 1'b0} || e.y !== 8'h03) begin
      errors++;
      $display("FAIL acc_hold_mode0: got y=%h p=%b, want y=03 p=0", y, y_parity);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) step(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1);
      else            step(1'b1, 3'd6, 1'b0, 1'b0, 8'(i), 8'h5A, 1'b1);
      e = sb.pop_front();
      if (i == 65534) begin
        checks++;
        if ({beat_cnt, y} !== {16'hFFFF, e.y}) begin
          errors++;
          $display("FAIL wrap_ffff: got cnt=%h y=%h, want cnt=ffff y=%h", beat_cnt, y, e.y);
        end
      end
    end
    checks++;
    if ({beat_cnt, y, y_zero, y_parity, out_valid} !== {16'h0000, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%h y=%h z=%b p=%b ov=%b, want cnt=0000 y=00 z=1 p=0 ov=1",
               beat_cnt, y, y_zero, y_parity, out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h81, 1'b1);
    e = sb.pop_front();
    step(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({out_valid, y, dut.r_acc} !== {1'b1, 8'h81, 8'h81}) begin
      errors++;
      $display("FAIL pre_reset_stall: got ov=%b y=%h acc=%h, want ov=1 y=81 acc=81", out_valid, y, dut.r_acc);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, y, y_zero, beat_cnt, dut.r_acc, in_ready} !== {1'b0, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got ov=%b y=%h z=%b cnt=%h acc=%h rdy=%b, want ov=0 y=00 z=1 cnt=0000 acc=00 rdy=1",
               out_valid, y, y_zero, beat_cnt, dut.r_acc, in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({out_valid, y, beat_cnt} !== {1'b1, 8'h02, 16'h0001} || e.y !== 8'h02) begin
      errors++;
      $display("FAIL post_reset_acc: got ov=%b y=%h cnt=%h, want ov=1 y=02 cnt=0001", out_valid, y, beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_op_sweep();
    test_stall();
    test_acc();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
  WIDTH  8  operand and result width in bits, legal range 1..64
  ACC_INIT  all-zeros  value loaded into the accumulator by reset and by acc_clr
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk  in  1  the only clock; all state updates on its rising edge
  rst_n  in  1  asynchronous, active-low reset
  in_valid  in  1  input beat offered
  in_ready  out  1  block can take an input beat
  op  in  3  operation select, sampled with the input beat
  acc_mode  in  1  1 = operand X is the internal accumulator; 0 = operand X is a
  acc_clr  in  1  synchronous accumulator clear
  a  in  WIDTH  operand A
  b  in  WIDTH  operand B
  out_valid  out  1  result held on y is valid
  out_ready  in  1  downstream takes the result
  y  out  WIDTH  registered result
  y_zero  out  1  registered flag, y == 0
  y_parity  out  1  registered XOR-reduction of y
  beat_cnt  out  16  count of accepted input beats
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-004 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-005 An input beat is accepted in any cycle with in_valid && in_ready; no other state SHALL change because of an input beat that is not accepted.
REQ-006 Operand X SHALL be ACC_INIT when acc_mode && acc_clr, acc when acc_mode && !acc_clr, and a otherwise.
REQ-007 op SHALL select the result R: 0 X&b, 1 X|b, 2 ~X, 3 ~b, 4 ~(X&b), 5 ~(X|b), 6 X^b, 7 ~(X^b); all 8 codes are legal.
REQ-008 On an accepted beat, y<=R, y_zero<=(R==0), y_parity<=^R and out_valid<=1 SHALL all update at the next edge, giving a latency of 1 cycle.
REQ-009 With no accepted beat and out_ready=1, out_valid SHALL go to 0 at the next edge; y and the flags SHALL keep their last values.
REQ-010 While out_valid && !out_ready, y, y_zero, y_parity and out_valid SHALL stay stable and in_ready SHALL be 0 (stall).
REQ-011 An accept in the same cycle as out_valid && out_ready SHALL load the new result with out_valid held at 1, with no bubble (full throughput).
REQ-012 The accumulator (WIDTH bits, internal) SHALL load R on an accepted beat with acc_mode=1.
REQ-013 Otherwise, acc_clr=1 SHALL load ACC_INIT into the accumulator; in all remaining cases the accumulator SHALL hold.
REQ-014 A beat accepted with acc_mode=0 SHALL leave the accumulator unchanged, unless acc_clr is also 1, in which case the accumulator SHALL be ACC_INIT.
REQ-015 acc_clr asserted in a cycle with no accepted beat SHALL NOT affect y or out_valid.
REQ-016 beat_cnt SHALL increment by 1 on each accepted beat and wrap from 0xFFFF to 0x0000.
REQ-017 All outputs except in_ready SHALL be driven directly from registers.

Reset
REQ-018 While rst_n=0 the block SHALL immediately force out_valid=0, y=0, y_zero=1, y_parity=0, beat_cnt=0 and accumulator=ACC_INIT; in_ready is then 1.
REQ-019 Reset asserted mid-operation SHALL discard any pending result and any stalled result.
REQ-020 The first beat SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Verification (WIDTH=8, ACC_INIT=0)
REQ-021 Beat a=0xF0, b=0x3C, op=6, acc_mode=0, out_ready=1 -> next cycle y=0xCC, y_zero=0, y_parity=0, out_valid=1, beat_cnt=1.
REQ-022 Sweep all op codes with a=0xA5, b=0x0F -> y = 0x05, 0xAF, 0x5A, 0xF0, 0xFA, 0x50, 0xAA, 0x55 in that order.
REQ-023 Hold out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, y stable, beat_cnt unchanged; set out_ready=1 -> the pending beat is accepted the same cycle and the next result appears with no bubble.
REQ-024 acc_mode=1, op=1, b=0x01, 0x02, 0x04 back-to-back -> y = 0x01, 0x03, 0x07; then acc_clr=1 with an accept, op=1, b=0x10 -> y=0x10.
REQ-025 Accept 65536 beats -> beat_cnt=0x0000; op=0 with a=0x00 -> y_zero=1.
REQ-026 Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0, y=0 and the accumulator is 0 immediately, without waiting for a clock edge.
